fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
- Holds the PC and issues word fetches to instruction memory. Applies redirects from execute, driven by the decoder's PCSrc code and the ALU Zero flag.
- Presents {instruction, pc, pc+4} with a valid bit to the decode stage, which feeds the control decoder.
- Supports variable-latency memory, decode stall and branch flush.

---
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch with IF/ID register.
// One outstanding imem request, skid for decode stall, execute redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [2:0]  ex_PCSrc,
  input  logic        ex_Zero,
  input  logic [31:0] ex_PCTarget,
  input  logic [31:0] ex_ALUResult,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misaligned
);

  localparam logic [2:0] PC_NEXT            = 3'd0;
  localparam logic [2:0] PC_COND_BRANCH     = 3'd1;
  localparam logic [2:0] PC_INV_COND_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL             = 3'd3;
  localparam logic [2:0] PC_JALR            = 3'd4;

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  if_id_t      id_q, id_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        discard, discard_n;
  logic        mis_q;
  logic        taken;
  logic [31:0] tgt_raw, tgt;
  logic        accept;
  logic        req;
  logic [31:0] addr;

  assign pc_plus4 = pc + 32'd4;
  assign accept   = !id_q.valid || !stall;

  always_comb begin
    taken   = 1'b0;
    tgt_raw = ex_PCTarget;
    unique case (ex_PCSrc)
      PC_NEXT:            taken = 1'b0;
      PC_COND_BRANCH:     taken = ex_Zero;
      PC_INV_COND_BRANCH: taken = !ex_Zero;
      PC_JAL:             taken = 1'b1;
      PC_JALR: begin
        taken   = 1'b1;
        tgt_raw = ex_ALUResult & ~32'h1;
      end
      default:            taken = 1'b0;
    endcase
  end

  assign tgt = tgt_raw & ~32'h3;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    discard_n    = discard;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    req          = 1'b0;
    addr         = pc;
    id_n         = id_q;
    if (id_q.valid && !stall) begin
      id_n.valid = 1'b0;
      id_n.instr = NOP_INSTR;
    end
    if (taken) begin
      pc_n         = tgt;
      id_n.valid   = 1'b0;
      id_n.instr   = NOP_INSTR;
      skid_instr_n = '0;
      skid_pc_n    = '0;
      // a request still in flight must be swallowed before refetch
      if (state == WAIT && !imem_rvalid) begin
        discard_n = 1'b1;
        state_n   = WAIT;
      end else begin
        discard_n = 1'b0;
        state_n   = ISSUE;
      end
    end else begin
      unique case (state)
        ISSUE: begin
          req     = 1'b1;
          state_n = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = ISSUE;
            end else if (accept) begin
              id_n = '{valid: 1'b1, instr: imem_rdata,
                       pc: pc, pc_plus4: pc_plus4};
              req  = 1'b1;
              addr = pc_plus4;
              pc_n = pc_plus4;
            end else begin
              skid_instr_n = imem_rdata;
              skid_pc_n    = pc;
              state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            id_n = '{valid: 1'b1, instr: skid_instr,
                     pc: skid_pc, pc_plus4: skid_pc + 32'd4};
            pc_n    = pc_plus4;
            state_n = ISSUE;
          end
        end
        default: state_n = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE;
      pc         <= RESET_PC;
      id_q       <= '{valid: 1'b0, instr: NOP_INSTR,
                      pc: 32'h0, pc_plus4: 32'h0};
      skid_instr <= '0;
      skid_pc    <= '0;
      discard    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      id_q       <= id_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      discard    <= discard_n;
      mis_q      <= taken && tgt_raw[1];
    end
  end

  assign imem_req    = req && !rst;
  assign imem_addr   = addr;
  assign id_valid    = id_q.valid;
  assign id_instr    = id_q.instr;
  assign id_pc       = id_q.pc;
  assign id_pc_plus4 = id_q.pc_plus4;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model returns addr>>2, scoreboard
// holds expected PCs in the order decode should consume them.
module tb_fetch_stage;

  localparam logic [2:0] PC_NEXT            = 3'd0;
  localparam logic [2:0] PC_COND_BRANCH     = 3'd1;
  localparam logic [2:0] PC_INV_COND_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL             = 3'd3;
  localparam logic [2:0] PC_JALR            = 3'd4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [2:0]  ex_PCSrc = PC_NEXT;
  logic        ex_Zero = 1'b0;
  logic [31:0] ex_PCTarget = '0;
  logic [31:0] ex_ALUResult = '0;
  logic        stall = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ex_PCSrc(ex_PCSrc), .ex_Zero(ex_Zero),
    .ex_PCTarget(ex_PCTarget), .ex_ALUResult(ex_ALUResult),
    .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .misaligned(misaligned)
  );

  // memory: fixed latency, one request at a time
  int          lat = 1;
  logic        m_busy;
  logic [31:0] m_addr;
  int          m_cnt;

  assign imem_rvalid = m_busy && (m_cnt == 0);
  assign imem_rdata  = m_addr >> 2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_addr <= '0;
      m_cnt  <= 0;
    end else if (imem_req) begin
      m_busy <= 1'b1;
      m_addr <= imem_addr;
      m_cnt  <= lat - 1;
    end else if (imem_rvalid) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: decode consumes IF/ID whenever valid and not stalled
  always @(negedge clk) begin
    if (!rst && id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, nothing expected",
                 id_pc);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e);
        check("id_instr", id_instr, e >> 2);
        check("id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst          = 1'b1;
    stall        = 1'b1;
    ex_PCSrc     = PC_NEXT;
    ex_Zero      = 1'b0;
    ex_PCTarget  = '0;
    ex_ALUResult = '0;
    lat          = l;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    stall = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    check({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, "_instr"}, id_instr, NOP);
    check({tag, "_pc"}, id_pc, 32'h0);
    check({tag, "_pc4"}, id_pc_plus4, 32'h0);
    check({tag, "_mis"}, {31'b0, misaligned}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset, streaming, then a 3-cycle decode stall
    lat = 1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    #1;
    check("a_req0", {31'b0, imem_req}, 32'h1);
    check("a_addr0", imem_addr, 32'h0);
    tick();
    check("a_addr1", imem_addr, 32'h4);
    tick();
    check("a_valid2", {31'b0, id_valid}, 32'h1);
    check("a_addr2", imem_addr, 32'h8);
    tick();
    check("a_addr3", imem_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      stall = 1'b1;
      #1;
      check("b_hold_pc", id_pc, 32'h8);
      check("b_hold_req", {31'b0, imem_req}, 32'h0);
    end
    tick();
    stall = 1'b0;
    #1;
    check("b_release_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("b_pc_c", id_pc, 32'hC);
    check("b_addr10", imem_addr, 32'h10);
    drain("stall");

    // taken and not-taken conditional branch
    do_reset(1);
    exp_q = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h48, 32'h4C};
    tick();
    tick();
    tick();
    ex_PCSrc    = PC_COND_BRANCH;
    ex_Zero     = 1'b1;
    ex_PCTarget = 32'h40;
    #1;
    check("c_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    ex_PCSrc = PC_NEXT;
    #1;
    check("c_flush_valid", {31'b0, id_valid}, 32'h0);
    check("c_flush_instr", id_instr, NOP);
    check("c_tgt_addr", imem_addr, 32'h40);
    check("c_tgt_req", {31'b0, imem_req}, 32'h1);
    check("c_no_mis", {31'b0, misaligned}, 32'h0);
    tick();
    tick();
    check("c_pc40", id_pc, 32'h40);
    tick();
    ex_PCSrc    = PC_COND_BRANCH;
    ex_Zero     = 1'b0;
    ex_PCTarget = 32'h80;
    #1;
    check("c_nt_req", {31'b0, imem_req}, 32'h1);
    check("c_nt_addr", imem_addr, 32'h4C);
    tick();
    ex_PCSrc = PC_NEXT;
    drain("branch");

    // jal from ISSUE, then misaligned jalr over an in-flight fetch
    do_reset(3);
    ex_PCSrc    = PC_JAL;
    ex_PCTarget = 32'h20;
    #1;
    check("d_jal_req", {31'b0, imem_req}, 32'h0);
    tick();
    ex_PCSrc = PC_NEXT;
    #1;
    check("d_addr20", imem_addr, 32'h20);
    check("d_req20", {31'b0, imem_req}, 32'h1);
    check("d_jal_mis", {31'b0, misaligned}, 32'h0);
    tick();
    ex_PCSrc     = PC_JALR;
    ex_ALUResult = 32'h103;
    ex_PCTarget  = 32'h200;
    #1;
    check("d_jalr_req", {31'b0, imem_req}, 32'h0);
    tick();
    ex_PCSrc = PC_NEXT;
    #1;
    check("d_mis_pulse", {31'b0, misaligned}, 32'h1);
    check("d_wait_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("d_mis_clear", {31'b0, misaligned}, 32'h0);
    check("d_drop_req", {31'b0, imem_req}, 32'h0);
    check("d_drop_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("d_addr100", imem_addr, 32'h100);
    check("d_req100", {31'b0, imem_req}, 32'h1);
    exp_q.push_back(32'h100);
    drain("jalr");

    // inverted branch coinciding with stall and a response
    do_reset(1);
    tick();
    tick();
    ex_PCSrc    = PC_INV_COND_BRANCH;
    ex_Zero     = 1'b0;
    ex_PCTarget = 32'h60;
    stall       = 1'b1;
    #1;
    check("e_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    ex_PCSrc = PC_NEXT;
    stall    = 1'b0;
    #1;
    check("e_flush_valid", {31'b0, id_valid}, 32'h0);
    check("e_flush_instr", id_instr, NOP);
    check("e_addr60", imem_addr, 32'h60);
    check("e_req60", {31'b0, imem_req}, 32'h1);
    exp_q.push_back(32'h60);
    drain("inv");

    // reset while waiting with a live IF/ID entry
    do_reset(3);
    tick();
    tick();
    tick();
    tick();
    stall = 1'b1;
    #1;
    check("f_live_valid", {31'b0, id_valid}, 32'h1);
    check("f_live_pc", id_pc, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("f_rst");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    check("f_req_after", {31'b0, imem_req}, 32'h1);
    check("f_addr_after", imem_addr, 32'h0);
    exp_q.push_back(32'h0);
    drain("rst");

    // PC wraps past the top of the address space
    do_reset(1);
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    ex_PCSrc    = PC_JAL;
    ex_PCTarget = 32'hFFFF_FFFC;
    tick();
    ex_PCSrc = PC_NEXT;
    #1;
    check("g_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("g_addr_wrap", imem_addr, 32'h0);
    check("g_req_wrap", {31'b0, imem_req}, 32'h1);
    drain("wrap");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
